// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_VALID = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: PC register controls, instruction-memory port and decode handshake.
interface fetch_ctrl_if #(
    parameter int XLEN = fetch_ctrl_pkg::XLEN
);
    logic            FETCH_EN;
    logic [XLEN-1:0] PC_IN;
    logic            PC_ENABLE;
    logic            PC_MODE;
    logic [XLEN-1:0] PC_D;
    logic            JUMP;
    logic [XLEN-1:0] JUMP_TARGET;
    logic            INSTR_REQ;
    logic [XLEN-1:0] INSTR_ADDR;
    logic            INSTR_GNT;
    logic            INSTR_RVALID;
    logic [XLEN-1:0] INSTR_RDATA;
    logic            IF_VALID;
    logic [XLEN-1:0] IF_INSTR;
    logic [XLEN-1:0] IF_PC;
    logic            ID_READY;

    // master: the fetch sequencer itself
    modport master (
        input  FETCH_EN, PC_IN, JUMP, JUMP_TARGET,
               INSTR_GNT, INSTR_RVALID, INSTR_RDATA, ID_READY,
        output PC_ENABLE, PC_MODE, PC_D, INSTR_REQ, INSTR_ADDR,
               IF_VALID, IF_INSTR, IF_PC
    );

    modport slave (
        output FETCH_EN, PC_IN, JUMP, JUMP_TARGET,
               INSTR_GNT, INSTR_RVALID, INSTR_RDATA, ID_READY,
        input  PC_ENABLE, PC_MODE, PC_D, INSTR_REQ, INSTR_ADDR,
               IF_VALID, IF_INSTR, IF_PC
    );

endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch sequencer driving PC controls, imem port and decode handoff.
//   state    | meaning
//   ST_IDLE  | no fetch in flight, waiting for FETCH_EN
//   ST_REQ   | request asserted at PC_IN, waiting for grant
//   ST_WAIT  | granted, waiting for read data (kill drops it after a jump)
//   ST_VALID | instruction presented to decode until accepted
module fetch_ctrl #(
    parameter int XLEN = fetch_ctrl_pkg::XLEN
) (
    input  logic         CLK,
    input  logic         RES,
    fetch_ctrl_if.master bus
);
    import fetch_ctrl_pkg::*;

    fetch_state_e    r_state;
    logic            r_kill;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_instr;
    logic [XLEN-1:0] r_if_pc;

    fetch_state_e    w_state_nxt;
    logic            w_kill_nxt;
    logic            w_if_valid_nxt;
    logic            w_cap_pc;
    logic            w_cap_instr;
    logic            w_req;
    logic            w_gnt_ok;

    // a jump steals the cycle: no request, so the PC never sees a +4 alongside a load
    assign w_req    = (r_state == ST_REQ) && !bus.JUMP;
    assign w_gnt_ok = w_req && bus.INSTR_GNT;

    assign bus.INSTR_REQ  = w_req;
    assign bus.INSTR_ADDR = bus.PC_IN;
    assign bus.PC_ENABLE  = bus.JUMP || w_gnt_ok;
    assign bus.PC_MODE    = bus.JUMP;
    assign bus.PC_D       = bus.JUMP_TARGET;
    assign bus.IF_VALID   = r_if_valid;
    assign bus.IF_INSTR   = r_if_instr;
    assign bus.IF_PC      = r_if_pc;

    always_comb begin
        w_state_nxt    = r_state;
        w_kill_nxt     = r_kill;
        w_if_valid_nxt = r_if_valid;
        w_cap_pc       = 1'b0;
        w_cap_instr    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!bus.JUMP && bus.FETCH_EN) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_gnt_ok) begin
                    w_cap_pc    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.INSTR_RVALID) begin
                    if (r_kill || bus.JUMP) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_cap_instr    = 1'b1;
                        w_if_valid_nxt = 1'b1;
                        w_state_nxt    = ST_VALID;
                    end
                end else if (bus.JUMP) begin
                    w_kill_nxt = 1'b1;
                end
            end
            ST_VALID: begin
                if (bus.JUMP) begin
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = ST_REQ;
                end else if (bus.ID_READY) begin
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = bus.FETCH_EN ? ST_REQ : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_state    <= ST_IDLE;
            r_kill     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_kill     <= w_kill_nxt;
            r_if_valid <= w_if_valid_nxt;
            if (w_cap_pc) begin
                r_if_pc <= bus.PC_IN;
            end
            if (w_cap_instr) begin
                r_if_instr <= bus.INSTR_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC register and a delivery scoreboard.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic CLK;
    logic RES;
    int   n_total;
    int   n_bad;

    logic [31:0] pc_reg;
    logic [63:0] sb[$];
    logic [63:0] sb_item;

    fetch_ctrl_if #(.XLEN(32)) bus ();

    fetch_ctrl #(.XLEN(32)) u_dut (
        .CLK (CLK),
        .RES (RES),
        .bus (bus.master)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // PC register model: +4 or load, owned by the environment
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            pc_reg <= 32'h1A00_0000;
        end else if (bus.PC_ENABLE) begin
            pc_reg <= bus.PC_MODE ? bus.PC_D : pc_reg + 32'd4;
        end
    end
    assign bus.PC_IN = pc_reg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // decode side: every accepted instruction must match the oldest expected one
    always @(negedge CLK) begin
        if (RES && bus.IF_VALID && bus.ID_READY) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                sb_item = sb.pop_front();
                chk("sb_pc", bus.IF_PC, sb_item[63:32]);
                chk("sb_instr", bus.IF_INSTR, sb_item[31:0]);
            end
        end
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        RES = 1'b1;
        bus.FETCH_EN = 1'b0;
        bus.JUMP = 1'b0;
        bus.JUMP_TARGET = '0;
        bus.INSTR_GNT = 1'b0;
        bus.INSTR_RVALID = 1'b0;
        bus.INSTR_RDATA = '0;
        bus.ID_READY = 1'b0;
        #2 RES = 1'b0;
        #1;
        chk("rst_if_valid", 32'(bus.IF_VALID), 32'd0);
        chk("rst_if_instr", bus.IF_INSTR, 32'd0);
        chk("rst_if_pc", bus.IF_PC, 32'd0);
        chk("rst_req", 32'(bus.INSTR_REQ), 32'd0);
        chk("rst_pc_en", 32'(bus.PC_ENABLE), 32'd0);
        chk("rst_pc_mode", 32'(bus.PC_MODE), 32'd0);
        tick();
        tick();
        RES = 1'b1;

        // 1: basic fetch, grant and data each in one cycle
        bus.FETCH_EN = 1'b1;
        #1 chk("t1_idle_req", 32'(bus.INSTR_REQ), 32'd0);
        tick();
        bus.INSTR_GNT = 1'b1;
        #1;
        chk("t1_req", 32'(bus.INSTR_REQ), 32'd1);
        chk("t1_addr", bus.INSTR_ADDR, 32'h1A00_0000);
        chk("t1_pc_en", 32'(bus.PC_ENABLE), 32'd1);
        chk("t1_pc_mode", 32'(bus.PC_MODE), 32'd0);
        tick();
        bus.INSTR_GNT = 1'b0;
        bus.INSTR_RVALID = 1'b1;
        bus.INSTR_RDATA = NOP_INSTR;
        bus.ID_READY = 1'b1;
        sb.push_back({32'h1A00_0000, NOP_INSTR});
        #1 chk("t1_wait_req", 32'(bus.INSTR_REQ), 32'd0);
        tick();
        bus.INSTR_RVALID = 1'b0;
        bus.FETCH_EN = 1'b0;
        #1;
        chk("t1_valid", 32'(bus.IF_VALID), 32'd1);
        chk("t1_if_pc", bus.IF_PC, 32'h1A00_0000);
        chk("t1_if_instr", bus.IF_INSTR, NOP_INSTR);
        tick();
        chk("t1_valid_drop", 32'(bus.IF_VALID), 32'd0);

        // 2: grant delayed by three cycles
        bus.FETCH_EN = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_req_hold", 32'(bus.INSTR_REQ), 32'd1);
            chk("t2_addr_hold", bus.INSTR_ADDR, 32'h1A00_0004);
            chk("t2_no_pc_en", 32'(bus.PC_ENABLE), 32'd0);
            tick();
        end
        bus.INSTR_GNT = 1'b1;
        #1;
        chk("t2_req_gnt", 32'(bus.INSTR_REQ), 32'd1);
        chk("t2_addr_gnt", bus.INSTR_ADDR, 32'h1A00_0004);
        chk("t2_pc_en_gnt", 32'(bus.PC_ENABLE), 32'd1);
        tick();

        // 3: decode stalls for four cycles
        bus.INSTR_GNT = 1'b0;
        bus.INSTR_RVALID = 1'b1;
        bus.INSTR_RDATA = 32'hDEAD_BEEF;
        bus.ID_READY = 1'b0;
        sb.push_back({32'h1A00_0004, 32'hDEAD_BEEF});
        tick();
        bus.INSTR_RVALID = 1'b0;
        bus.INSTR_RDATA = 32'h0BAD_0BAD;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_valid_hold", 32'(bus.IF_VALID), 32'd1);
            chk("t3_instr_hold", bus.IF_INSTR, 32'hDEAD_BEEF);
            chk("t3_pc_hold", bus.IF_PC, 32'h1A00_0004);
            chk("t3_no_req", 32'(bus.INSTR_REQ), 32'd0);
            tick();
        end
        bus.ID_READY = 1'b1;
        tick();

        // 4: jump while waiting for data, stale data dropped
        bus.INSTR_GNT = 1'b1;
        #1 chk("t4_addr", bus.INSTR_ADDR, 32'h1A00_0008);
        tick();
        bus.INSTR_GNT = 1'b0;
        bus.JUMP = 1'b1;
        bus.JUMP_TARGET = 32'h1A00_0100;
        #1;
        chk("t4_pc_en", 32'(bus.PC_ENABLE), 32'd1);
        chk("t4_pc_mode", 32'(bus.PC_MODE), 32'd1);
        chk("t4_pc_d", bus.PC_D, 32'h1A00_0100);
        tick();
        bus.JUMP = 1'b0;
        #1 chk("t4_pc_en_pulse", 32'(bus.PC_ENABLE), 32'd0);
        tick();
        bus.INSTR_RVALID = 1'b1;
        bus.INSTR_RDATA = 32'hBAD0_0001;
        tick();
        bus.INSTR_RVALID = 1'b0;
        #1;
        chk("t4_dropped", 32'(bus.IF_VALID), 32'd0);
        chk("t4_req", 32'(bus.INSTR_REQ), 32'd1);
        chk("t4_new_addr", bus.INSTR_ADDR, 32'h1A00_0100);

        // 5: jump in REQ while memory grants
        bus.INSTR_GNT = 1'b1;
        bus.JUMP = 1'b1;
        bus.JUMP_TARGET = 32'h1A00_0200;
        #1;
        chk("t5_req_supp", 32'(bus.INSTR_REQ), 32'd0);
        chk("t5_pc_en", 32'(bus.PC_ENABLE), 32'd1);
        chk("t5_pc_mode", 32'(bus.PC_MODE), 32'd1);
        tick();
        bus.JUMP = 1'b0;
        #1;
        chk("t5_if_pc_kept", bus.IF_PC, 32'h1A00_0008);
        chk("t5_req", 32'(bus.INSTR_REQ), 32'd1);
        chk("t5_addr", bus.INSTR_ADDR, 32'h1A00_0200);
        chk("t5_pc_mode_inc", 32'(bus.PC_MODE), 32'd0);
        tick();
        bus.INSTR_GNT = 1'b0;
        chk("t5_if_pc_new", bus.IF_PC, 32'h1A00_0200);

        // 6: asynchronous reset while in WAIT
        #2 RES = 1'b0;
        #1;
        chk("t6_if_valid", 32'(bus.IF_VALID), 32'd0);
        chk("t6_req", 32'(bus.INSTR_REQ), 32'd0);
        chk("t6_if_pc", bus.IF_PC, 32'd0);
        tick();
        RES = 1'b1;
        bus.FETCH_EN = 1'b0;
        bus.INSTR_RVALID = 1'b1;
        bus.INSTR_RDATA = 32'hBAD0_0002;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_stale_valid", 32'(bus.IF_VALID), 32'd0);
            chk("t6_stale_req", 32'(bus.INSTR_REQ), 32'd0);
        end

        // back-to-back fetches at three cycles each
        bus.INSTR_RVALID = 1'b0;
        bus.FETCH_EN = 1'b1;
        bus.ID_READY = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.INSTR_GNT = 1'b1;
            #1 chk("bb_addr", bus.INSTR_ADDR, 32'h1A00_0000 + 32'(4 * i));
            tick();
            bus.INSTR_GNT = 1'b0;
            bus.INSTR_RVALID = 1'b1;
            bus.INSTR_RDATA = 32'h0000_1000 + 32'(i);
            sb.push_back({32'h1A00_0000 + 32'(4 * i), 32'h0000_1000 + 32'(i)});
            tick();
            bus.INSTR_RVALID = 1'b0;
            #1 chk("bb_valid", 32'(bus.IF_VALID), 32'd1);
            tick();
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that drives the program counter register's ENABLE/MODE/D controls and the instruction-memory request port. It issues one fetch at a time at the current PC and advances the PC by 4 on each accepted request. It applies jump redirects and discards stale responses. Fetched instructions are handed to decode through a valid/ready handshake. It sits between the PC register, instruction memory and the decode stage.

Parameters:
XLEN, 32, width of PC, addresses and instruction word

Ports:
CLK  in  1  clock; all state updates on rising edge
RES  in  1  reset, asynchronous, active-low
FETCH_EN  in  1  permits new fetches when 1
PC_IN  in  XLEN  current value of PC register
PC_ENABLE  out  1  to PC register ENABLE
PC_MODE  out  1  to PC register MODE (0 = +4, 1 = load PC_D)
PC_D  out  XLEN  jump target to PC register
JUMP  in  1  single-cycle redirect pulse
JUMP_TARGET  in  XLEN  redirect address, valid with JUMP
INSTR_REQ  out  1  memory request
INSTR_ADDR  out  XLEN  request address
INSTR_GNT  in  1  request accepted; only meaningful while INSTR_REQ=1
INSTR_RVALID  in  1  read data valid
INSTR_RDATA  in  XLEN  read data
IF_VALID  out  1  instruction available to decode
IF_INSTR  out  XLEN  fetched instruction
IF_PC  out  XLEN  address of IF_INSTR
ID_READY  in  1  decode accepts when IF_VALID and ID_READY are both 1

Behaviour:
- States: IDLE, REQ, WAIT, VALID. Registers: state, kill flag, IF_INSTR, IF_PC, IF_VALID.
- Reset (RES=0, takes effect immediately, no clock needed): state=IDLE; kill=0; IF_VALID=0; IF_INSTR=0; IF_PC=0. Combinational outputs evaluate to 0 in IDLE with JUMP=0.
- INSTR_ADDR = PC_IN, combinational.
- INSTR_REQ = (state==REQ) && !JUMP.
- PC control, combinational, one-hot priority:
  - JUMP=1 in any state: PC_ENABLE=1, PC_MODE=1, PC_D=JUMP_TARGET.
  - Else INSTR_REQ && INSTR_GNT: PC_ENABLE=1, PC_MODE=0.
  - Else PC_ENABLE=0, PC_MODE=0.
  - PC_D=JUMP_TARGET at all times.
- IDLE: stay while FETCH_EN=0. FETCH_EN=1 -> REQ. A JUMP in IDLE loads the PC and keeps the state IDLE.
- REQ: hold INSTR_REQ with a stable address until grant. On INSTR_GNT with INSTR_REQ=1: IF_PC<=PC_IN, then -> WAIT. A JUMP here suppresses the request that cycle and keeps the state REQ. The next request uses the new PC_IN (the target).
- WAIT:
  - INSTR_RVALID, kill=0, JUMP=0: IF_INSTR<=INSTR_RDATA, IF_VALID<=1, -> VALID.
  - INSTR_RVALID with kill=1 or JUMP=1: drop data, kill<=0, -> REQ.
  - JUMP without RVALID: kill<=1, stay in WAIT.
- VALID: IF_VALID, IF_INSTR and IF_PC held stable until ID_READY=1.
  - On handshake: IF_VALID<=0, -> REQ if FETCH_EN=1, else IDLE.
  - JUMP (with or without ID_READY): IF_VALID<=0, -> REQ. The instruction is consumed if ID_READY=1, else squashed.
- Only one outstanding request. Minimum 3 cycles per instruction with GNT and RVALID each responding in one cycle.
- FETCH_EN=0 never aborts an in-flight fetch. It only blocks leaving IDLE and re-entering REQ from VALID.
- INSTR_RVALID in IDLE, REQ or VALID is ignored. This covers stale responses arriving after reset.
- PC arithmetic and wrap-around are owned by the PC register. This block performs no address arithmetic.

Decomposition:
- Shared package: XLEN constant, fetch state enum (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, VALID=2'd3), NOP encoding 32'h0000_0013 for benches.
- No sub-module: a single FSM plus capture registers.

Test Plan:
1. Reset release, FETCH_EN=1, PC_IN=0x1A000000, GNT same cycle as REQ, RVALID next cycle with RDATA=0x00000013, ID_READY=1 -> INSTR_REQ=1 with ADDR=0x1A000000; PC_ENABLE=1 and PC_MODE=0 in the grant cycle; IF_VALID=1 for one cycle with IF_PC=0x1A000000 and IF_INSTR=0x00000013.
2. GNT delayed 3 cycles -> INSTR_REQ and INSTR_ADDR held constant for 4 cycles; PC_ENABLE=0 until the grant cycle.
3. ID_READY=0 for 4 cycles in VALID -> IF_VALID, IF_INSTR and IF_PC unchanged; INSTR_REQ=0 throughout.
4. JUMP with JUMP_TARGET=0x1A000100 in WAIT, RVALID 2 cycles later -> PC_ENABLE=1 and PC_MODE=1 for 1 cycle; RVALID data dropped with IF_VALID kept at 0; next INSTR_ADDR=0x1A000100.
5. JUMP in REQ while memory drives GNT=1 -> INSTR_REQ=0 that cycle; no +4 pulse; IF_PC not updated; next request addresses the target.
6. RES driven low between clock edges while in WAIT -> IF_VALID=0 and INSTR_REQ=0 immediately; a later RVALID in IDLE produces no IF_VALID.
